// File: rtl/p2s_rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg
// Shared definitions for the parallel-to-serial scheduler and its planned
// serial-to-parallel counterpart.
//   P2S_W      : word width shared with the shifter instance
//   state_e    : scheduler states
//   rr_search  : round-robin first-set search (up to 8 requesters)
// ---------------------------------------------------------------------------
package p2s_pkg;

    localparam int unsigned P2S_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // Index of the first set bit of req[n-1:0], searching upward from ptr and
    // wrapping at n. Returns 0 when nothing is set; callers qualify with |req.
    function automatic int unsigned rr_search(input logic [7:0]  req,
                                              input logic [2:0]  ptr,
                                              input int unsigned n);
        int unsigned idx;
        int unsigned j;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) begin
                j = (32'(ptr) + i) % n;
                if (!found && req[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/p2s_rr_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this pick
//   found_o : at least one request is set
//   idx_o   : first set request at or above ptr_i, with wrap-around
// ---------------------------------------------------------------------------
module rr_pick
    import p2s_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     found_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    assign found_o = |req_i;
    assign idx_o   = IW'(rr_search(8'(req_i), 3'(ptr_i), N_REQ));

endmodule

// File: rtl/p2s_rr_sched.sv
// ---------------------------------------------------------------------------
// p2s_rr_sched
// Round-robin scheduler sharing one LSB-first parallel-to-serial shifter
// among N_REQ word producers.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_i / data_i    : per-requester request and word (word i at [i*W +: W])
//   ack_o             : one-cycle pulse, word loaded into the shifter
//   done_o            : one-cycle pulse, word fully shifted out
//   busy_o, gnt_id_o  : scheduler active / current owner
//   err_to_o          : sticky shifter timeout
//   ser_load_o, ser_enable_o, ser_par_in_o, ser_valid_i : shifter interface
// ---------------------------------------------------------------------------
module p2s_rr_sched
    import p2s_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned W      = P2S_W,
    parameter int unsigned GAP    = 1,
    parameter int unsigned TO_LIM = W + 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*W-1:0]       data_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] gnt_id_o,
    output logic                     err_to_o,
    output logic                     ser_load_o,
    output logic                     ser_enable_o,
    output logic [W-1:0]             ser_par_in_o,
    input  logic                     ser_valid_i
);

    localparam int unsigned IW  = $clog2(N_REQ);
    localparam int unsigned SHW = $clog2(TO_LIM + 1);

    state_e             state_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      gnt_q;
    logic               err_q;
    logic [N_REQ-1:0]   ack_q;
    logic [N_REQ-1:0]   done_q;
    logic               load_q;
    logic [W-1:0]       par_q;
    logic [SHW-1:0]     sh_cnt_q;
    logic [3:0]         gap_cnt_q;

    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [W-1:0]       pick_word;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_word = data_i[32'(pick_idx) * W +: W];
    end

    // ack, load and the shifter word are registered on the IDLE->LOAD edge
    // so they are visible exactly during the LOAD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            err_q     <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            load_q    <= 1'b0;
            par_q     <= '0;
            sh_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt_q           <= pick_idx;
                        ack_q[pick_idx] <= 1'b1;
                        load_q          <= 1'b1;
                        par_q           <= pick_word;
                        state_q         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rr_ptr_q <= (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    sh_cnt_q <= '0;
                    state_q  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sh_cnt_q <= sh_cnt_q + 1'b1;
                    if (ser_valid_i) begin
                        done_q[gnt_q] <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= (GAP == 0) ? ST_IDLE : ST_GAP;
                    end else if (sh_cnt_q == SHW'(TO_LIM - 1)) begin
                        err_q     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= (GAP == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'(GAP - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_o        = ack_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign gnt_id_o     = gnt_q;
    assign err_to_o     = err_q;
    assign ser_load_o   = load_q;
    assign ser_enable_o = (state_q == ST_SHIFT);
    assign ser_par_in_o = par_q;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_p2s_rr_sched
// Two scheduler instances (GAP=1 and GAP=0), each driving a behavioural
// LSB-first shifter that raises valid after W+1 enables following a load.
// ---------------------------------------------------------------------------
module tb_p2s_rr_sched;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req  [2];
    logic [N*W-1:0] data [2];
    logic [N-1:0]   ack  [2];
    logic [N-1:0]   done [2];
    logic           busy [2];
    logic [1:0]     gnt  [2];
    logic           err  [2];
    logic           ld   [2];
    logic           en   [2];
    logic [W-1:0]   par  [2];
    logic           vld  [2];
    logic           kill [2];
    logic [W-1:0]   cap  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        p2s_rr_sched #(
            .N_REQ (N),
            .W     (W),
            .GAP   ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_i        (req[g]),
            .data_i       (data[g]),
            .ack_o        (ack[g]),
            .done_o       (done[g]),
            .busy_o       (busy[g]),
            .gnt_id_o     (gnt[g]),
            .err_to_o     (err[g]),
            .ser_load_o   (ld[g]),
            .ser_enable_o (en[g]),
            .ser_par_in_o (par[g]),
            .ser_valid_i  (vld[g])
        );

        // Shifter model; count starts full so valid is stale-high at power-up.
        logic [W-1:0] sr = '0;
        logic [5:0]   cnt = 6'd33;
        logic [W-1:0] cp = '0;
        always @(posedge clk) begin
            if (ld[g]) begin
                sr  <= par[g];
                cnt <= '0;
            end else if (en[g] && cnt < 6'd33) begin
                if (cnt < 6'd32) cp <= {sr[0], cp[W-1:1]};
                sr  <= sr >> 1;
                cnt <= cnt + 6'd1;
            end
        end
        assign vld[g] = (cnt == 6'd33) && !kill[g];
        assign cap[g] = cp;
    end

    int cyc = 0;
    int dn1 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done[1] != '0) dn1 <= dn1 + 1;
    end

    logic [W-1:0] wd [4];
    int checks = 0;
    int errors = 0;
    int last_ack = 0;

    typedef struct {
        logic [3:0] rq;
        bit         hold;
        int         idx;
        int         spacing;
        bit         idle_first;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int g, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ack[g] != '0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy[0] && n < 100) begin
            step();
            n++;
        end
        chk("idle_wait", busy[0], 0);
    endtask

    // One full transfer on the GAP=1 instance.
    task automatic run_xfer(input logic [3:0] rq, input bit hold, input int idx,
                            input int spacing, input bit idle_first);
        int t_req, t_ack, t_done, ens;
        bit ok;
        if (idle_first) wait_idle();
        t_req  = cyc;
        req[0] = rq;
        wait_ack(0, t_ack, ok);
        chk("ack_seen", ok, 1);
        if (!ok) return;
        chk("ack_vec", ack[0], 64'(1 << idx));
        chk("gnt_id", gnt[0], idx);
        chk("ser_load", ld[0], 1);
        chk("ser_par_in", par[0], wd[idx]);
        if (idle_first) chk("ack_latency", t_ack - t_req, 1);
        if (spacing > 0) chk("ack_spacing", t_ack - last_ack, spacing);
        last_ack = t_ack;
        if (!hold) req[0] = req[0] & ~ack[0];
        ens = 0;
        ok  = 1'b0;
        t_done = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done[0] != '0) begin
                ok = 1'b1;
                t_done = cyc;
                break;
            end
            if (en[0]) ens++;
        end
        chk("done_seen", ok, 1);
        chk("done_vec", done[0], 64'(1 << idx));
        chk("done_latency", t_done - t_ack, 35);
        chk("enable_cycles", ens, 34);
        chk("serial_stream", cap[0], wd[idx]);
    endtask

    initial begin
        int  t0, t1, ens, dn;
        bit  ok;

        wd[0] = 32'h0000_0001;
        wd[1] = 32'h0000_0002;
        wd[2] = 32'hA5A5_0F0F;
        wd[3] = 32'h0000_0008;

        vecs[0]  = '{4'b1111, 1'b1, 0, 0,  1'b1};
        vecs[1]  = '{4'b1111, 1'b1, 1, 37, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 2, 37, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 3, 37, 1'b0};
        vecs[4]  = '{4'b0001, 1'b0, 0, 37, 1'b0};
        vecs[5]  = '{4'b0100, 1'b0, 2, 0,  1'b1};
        vecs[6]  = '{4'b0010, 1'b0, 1, 0,  1'b1};
        vecs[7]  = '{4'b1010, 1'b0, 3, 0,  1'b1};
        vecs[8]  = '{4'b0010, 1'b0, 1, 37, 1'b0};
        vecs[9]  = '{4'b0101, 1'b0, 2, 37, 1'b0};
        vecs[10] = '{4'b0001, 1'b0, 0, 37, 1'b0};

        kill[0] = 1'b0;
        kill[1] = 1'b0;
        req[0]  = '0;
        req[1]  = '0;
        data[0] = {wd[3], wd[2], wd[1], wd[0]};
        data[1] = {wd[3], wd[2], wd[1], wd[0]};

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", busy[0], 0);
        chk("rst_ack", ack[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_load", ld[0], 0);
        chk("rst_enable", en[0], 0);
        chk("rst_par", par[0], 0);
        chk("rst_gnt", gnt[0], 0);
        chk("rst_err", err[0], 0);
        repeat (5) step();
        chk("idle_busy", busy[0], 0);

        for (int v = 0; v < 11; v++) begin
            run_xfer(vecs[v].rq, vecs[v].hold, vecs[v].idx,
                     vecs[v].spacing, vecs[v].idle_first);
        end
        chk("gnt_hold_idle", gnt[0], 0);

        // Timeout: valid suppressed, req[3] queued behind the stuck transfer.
        kill[0] = 1'b1;
        wait_idle();
        req[0] = 4'b0001;
        wait_ack(0, t0, ok);
        chk("to_ack_vec", ack[0], 4'b0001);
        req[0] = 4'b1000;
        ens = 0;
        dn  = 0;
        ok  = 1'b0;
        t1  = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done[0] != '0) dn++;
            if (err[0]) begin
                ok = 1'b1;
                t1 = cyc;
                break;
            end
            if (en[0]) ens++;
        end
        chk("to_err_set", ok, 1);
        chk("to_err_latency", t1 - t0, 36);
        chk("to_shift_cycles", ens, 35);
        chk("to_no_done", dn, 0);
        kill[0] = 1'b0;
        last_ack = t0;
        run_xfer(4'b1000, 1'b0, 3, 38, 1'b0);
        chk("to_err_sticky", err[0], 1);

        // Reset in the middle of SHIFT with requests 0 and 3 pending.
        wait_idle();
        req[0] = 4'b0010;
        wait_ack(0, t0, ok);
        chk("mid_ack_vec", ack[0], 4'b0010);
        req[0] = 4'b1001;
        repeat (19) step();
        chk("mid_in_shift", en[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_enable", en[0], 0);
        chk("mid_rst_done", done[0], 0);
        chk("mid_rst_err", err[0], 0);
        chk("mid_rst_gnt", gnt[0], 0);
        step();
        chk("mid_regrant_ack", ack[0], 4'b0001);
        req[0] = 4'b1000;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done[0] != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_done_seen", ok, 1);
        chk("mid_done_vec", done[0], 4'b0001);
        run_xfer(4'b1000, 1'b0, 3, 0, 1'b0);

        // GAP=0 instance: stale valid ignored, back-to-back grants every 36.
        chk("g0_no_spurious_done", dn1, 0);
        chk("g0_idle", busy[1], 0);
        t1 = cyc;
        req[1] = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, t0, ok);
            chk("g0_ack_seen", ok, 1);
            chk("g0_ack_vec", ack[1], 4'b0001);
            if (k == 0) chk("g0_ack_latency", t0 - t1, 1);
            else        chk("g0_ack_spacing", t0 - last_ack, 36);
            last_ack = t0;
            if (k == 2) req[1] = '0;
            ok = 1'b0;
            t1 = 0;
            for (int i = 0; i < 60; i++) begin
                step();
                if (done[1] != '0) begin
                    ok = 1'b1;
                    t1 = cyc;
                    break;
                end
            end
            chk("g0_done_seen", ok, 1);
            chk("g0_done_vec", done[1], 4'b0001);
            chk("g0_done_latency", t1 - t0, 35);
        end
        step();
        chk("g0_done_count", dn1, 3);
        repeat (3) step();
        chk("g0_idle_end", busy[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "time limit");
    end

endmodule
